// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel blink-pattern generator for board status LEDs.
// A shared prescaler makes a tick. Each channel counts ticks through a period
// whose length ramps with the channel's step index. Channels start on staggered
// steps. The LED is dark for the first DARK_TICKS ticks of each period and lit
// for the rest. The mode input can select a fixed period, or force every LED
// on or off. Forcing leaves the counters running, so a return to the ramp
// carries on without a glitch.
module led_pattern_gen #(
    parameter int CH             = 4,
    parameter int TICK_DIV       = 50_000,
    parameter int STEPS          = 9,
    parameter int BASE_TICKS     = 500,
    parameter int INC_TICKS      = 250,
    parameter int DARK_TICKS     = 250,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int CW             = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic [CH-1:0] led,
    output logic [3:0]    step0,
    output logic          cycle_done
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    LAST_STEP = 4'(STEPS - 1);
    localparam logic          LED_LIT   = (LED_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic          LED_DARK  = ~LED_LIT;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_ON    = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    // Shared prescaler
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // Per-channel tick counter, step index and registered pin level
    logic [CW-1:0] t_q [CH];
    logic [CW-1:0] t_d [CH];
    logic [3:0]    k_q [CH];
    logic [3:0]    k_d [CH];
    logic [CH-1:0] led_q, led_d;
    logic [31:0]   period [CH];
    logic [CH-1:0] wrap;

    logic          cycle_done_q, cycle_done_d;

    // Prescaler: advances only while enabled and holds its value during a pause
    always_comb begin
        presc_d = presc_q;
        tick    = en && (presc_q == PRESC_MAX);
        if (en) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
    end

    // Channel next state: period select, wrap/step advance on tick, pin level from next t
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            period[i] = '0;
            wrap[i]   = 1'b0;
            t_d[i]    = t_q[i];
            k_d[i]    = k_q[i];
            led_d[i]  = LED_DARK;

            // Forced modes keep the ramp period so the counters stay in step with mode 0
            if (mode == MODE_FIXED) begin
                period[i] = 32'(BASE_TICKS);
            end else begin
                period[i] = 32'(BASE_TICKS) + 32'(k_q[i]) * 32'(INC_TICKS);
            end

            // >= so a period that shrank below t wraps on the next tick instead of overrunning
            wrap[i] = (32'(t_q[i]) >= (period[i] - 32'd1));

            if (tick) begin
                if (wrap[i]) begin
                    t_d[i] = '0;
                    k_d[i] = (k_q[i] == LAST_STEP) ? 4'd0 : k_q[i] + 4'd1;
                end else begin
                    t_d[i] = t_q[i] + 1'b1;
                end
            end

            case (mode)
                MODE_ON:  led_d[i] = LED_LIT;
                MODE_OFF: led_d[i] = LED_DARK;
                default:  led_d[i] = (32'(t_d[i]) >= 32'(DARK_TICKS)) ? LED_LIT : LED_DARK;
            endcase
        end

        cycle_done_d = tick && wrap[0] && (k_q[0] == LAST_STEP);
    end

    // State registers; reset staggers channel i onto step i mod STEPS
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            led_q        <= {CH{LED_DARK}};
            cycle_done_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                t_q[i] <= '0;
                k_q[i] <= 4'(i % STEPS);
            end
        end else begin
            presc_q      <= presc_d;
            led_q        <= led_d;
            cycle_done_q <= cycle_done_d;
            for (int i = 0; i < CH; i++) begin
                t_q[i] <= t_d[i];
                k_q[i] <= k_d[i];
            end
        end
    end

    assign led        = led_q;
    assign step0      = k_q[0];
    assign cycle_done = cycle_done_q;

    // Keep the unused mode encoding visible as documentation of the decode above
    logic unused_ok;
    assign unused_ok = (MODE_RAMP == 2'd0);

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed test of led_pattern_gen with a small configuration
// (2 channels, 4-clock tick, 3 steps, periods 4/6/8 ticks, 2 dark ticks).
// Edge n is the nth rising clock edge after en rises.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] led;
    logic [3:0] step0;
    logic       cycle_done;

    int n_cmp;
    int n_err;
    int cyc;
    logic [3:0] exp_q[$];

    led_pattern_gen #(
        .CH(2), .TICK_DIV(4), .STEPS(3), .BASE_TICKS(4), .INC_TICKS(2),
        .DARK_TICKS(2), .LED_ACTIVE_LOW(1), .CW(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .led(led), .step0(step0), .cycle_done(cycle_done)
    );

    // Clock generator
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    // Advance to edge n; sampling and driving happen 1 time unit after the edge
    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Hold reset for two edges, check the reset state, then raise en
    task automatic do_reset(input logic [1:0] m);
        rst  = 1'b1;
        en   = 1'b0;
        mode = m;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        check("rst_led", 32'(led), 32'h3);
        check("rst_step0", 32'(step0), 32'd0);
        check("rst_cdone", 32'(cycle_done), 32'd0);
        check("rst_k1", 32'(dut.k_q[1]), 32'd1);
        check("rst_presc", 32'(dut.presc_q), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 2'd0;

        // Ramp mode: ch0 periods 16/24/32 clocks, ch1 starts at step 1
        do_reset(2'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd0);
        go_to(7);   check("ramp_dark_e7", 32'(led), 32'h3);
        go_to(8);   check("ramp_lit_e8", 32'(led), 32'h0);
        go_to(15);  check("ramp_lit_e15", 32'(led), 32'h0);
        go_to(16);  check("ramp_wrap_e16", 32'(led), 32'h1);
                    check("ramp_step_e16", 32'(step0), 32'(exp_q.pop_front()));
        go_to(24);  check("ramp_ch1_wrap_e24", 32'(led), 32'h2);
        go_to(40);  check("ramp_step_e40", 32'(step0), 32'(exp_q.pop_front()));
        go_to(71);  check("ramp_cdone_e71", 32'(cycle_done), 32'd0);
        go_to(72);  check("ramp_cdone_e72", 32'(cycle_done), 32'd1);
                    check("ramp_step_e72", 32'(step0), 32'(exp_q.pop_front()));
                    check("ramp_k1_e72", 32'(dut.k_q[1]), 32'd1);
        go_to(73);  check("ramp_cdone_e73", 32'(cycle_done), 32'd0);
        go_to(143); check("ramp_cdone_e143", 32'(cycle_done), 32'd0);
        go_to(144); check("ramp_cdone_e144", 32'(cycle_done), 32'd1);

        // Pause for 10 clocks after edge 12: everything shifts 10 clocks late
        do_reset(2'd0);
        go_to(12);
        en = 1'b0;
        go_to(17);  check("pause_led_e17", 32'(led), 32'h0);
                    check("pause_t0_e17", 32'(dut.t_q[0]), 32'd3);
                    check("pause_presc_e17", 32'(dut.presc_q), 32'd0);
        go_to(22);
        en = 1'b1;
        go_to(25);  check("pause_led_e25", 32'(led), 32'h0);
                    check("pause_step_e25", 32'(step0), 32'd0);
        go_to(26);  check("pause_led_e26", 32'(led), 32'h1);
                    check("pause_step_e26", 32'(step0), 32'd1);
        go_to(81);  check("pause_step_e81", 32'(step0), 32'd2);
                    check("pause_cdone_e81", 32'(cycle_done), 32'd0);
        go_to(82);  check("pause_cdone_e82", 32'(cycle_done), 32'd1);
        go_to(83);  check("pause_cdone_e83", 32'(cycle_done), 32'd0);

        // Fixed mode: every period 16 clocks, cycle_done every 48
        do_reset(2'd1);
        go_to(8);   check("fixed_lit_e8", 32'(led), 32'h0);
        go_to(16);  check("fixed_wrap_e16", 32'(led), 32'h3);
                    check("fixed_step_e16", 32'(step0), 32'd1);
        go_to(32);  check("fixed_step_e32", 32'(step0), 32'd2);
        go_to(47);  check("fixed_cdone_e47", 32'(cycle_done), 32'd0);
        go_to(48);  check("fixed_cdone_e48", 32'(cycle_done), 32'd1);
                    check("fixed_step_e48", 32'(step0), 32'd0);
        go_to(49);  check("fixed_cdone_e49", 32'(cycle_done), 32'd0);

        // Shrink the period under a running count: ch0 at step 2, t=6, then mode 1
        do_reset(2'd0);
        go_to(64);  check("shrink_t0_e64", 32'(dut.t_q[0]), 32'd6);
                    check("shrink_step_e64", 32'(step0), 32'd2);
        mode = 2'd1;
        go_to(67);  check("shrink_led0_e67", 32'(led[0]), 32'd0);
                    check("shrink_cdone_e67", 32'(cycle_done), 32'd0);
        go_to(68);  check("shrink_led0_e68", 32'(led[0]), 32'd1);
                    check("shrink_step_e68", 32'(step0), 32'd0);
                    check("shrink_cdone_e68", 32'(cycle_done), 32'd1);
        go_to(69);  check("shrink_cdone_e69", 32'(cycle_done), 32'd0);

        // Forced on/off take effect one edge after the change; counters keep running
        mode = 2'd2;
        go_to(70);  check("force_on_e70", 32'(led), 32'h0);
        go_to(77);  check("force_on_e77", 32'(led), 32'h0);
        mode = 2'd3;
        go_to(78);  check("force_off_e78", 32'(led), 32'h3);
        mode = 2'd0;
        go_to(79);  check("resume_ramp_e79", 32'(led), 32'h2);
                    check("resume_presc_e79", 32'(dut.presc_q), 32'd3);

        // One-cycle reset pulse mid-run, landing on what would be a tick edge
        rst = 1'b1;
        go_to(80);
        rst = 1'b0;
        check("pulse_led", 32'(led), 32'h3);
        check("pulse_step0", 32'(step0), 32'd0);
        check("pulse_k1", 32'(dut.k_q[1]), 32'd1);
        check("pulse_presc", 32'(dut.presc_q), 32'd0);
        check("pulse_cdone", 32'(cycle_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel, parametrised blink-pattern generator for board status LEDs. It is the successor to the single-LED ramped blinker.
- A shared prescaler produces a tick. Each channel steps through STEPS blink periods, with period length growing linearly per step.
- Channels start staggered. A mode input selects ramp, fixed-period, forced-on or forced-off.
- Sits directly behind the top-level LED pins. No bus interface.

Parameters:
- CH, 4, number of LED channels (1..16).
- TICK_DIV, 50_000, clock cycles per tick (1 ms at 50 MHz); must be >= 1.
- STEPS, 9, steps per pattern cycle (2..16).
- BASE_TICKS, 500, period of step 0 in ticks.
- INC_TICKS, 250, period increment per step in ticks.
- DARK_TICKS, 250, dark time at the start of every period in ticks; must be < BASE_TICKS.
- LED_ACTIVE_LOW, 1, 1: lit = 0 on the pin; 0: lit = 1.
- CW, 16, tick-counter width; must hold BASE_TICKS+(STEPS-1)*INC_TICKS-1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, run enable; 0 = pause.
- mode, input, 2, 0 ramp, 1 fixed, 2 all lit, 3 all dark.
- led, output, CH, LED pin levels.
- step0, output, 4, current step index of channel 0.
- cycle_done, output, 1, one-cycle pulse when channel 0 wraps from step STEPS-1 to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - prescaler = 0.
  - Per channel i: tick count t_i = 0, step k_i = i mod STEPS.
  - led = all dark (all 1 when LED_ACTIVE_LOW=1).
  - step0 = 0; cycle_done = 0.
  - Reset asserted mid-run returns everything to these values at the next edge; it overrides en and mode.
- Prescaler:
  - While en=1, counts 0..TICK_DIV-1 and wraps.
  - tick = en && prescaler==TICK_DIV-1.
  - While en=0, the prescaler holds its value.
- Period for a channel:
  - mode 0: P = BASE_TICKS + k_i*INC_TICKS.
  - mode 1: P = BASE_TICKS, independent of step.
  - mode 2/3: P as in mode 0. Counters keep running so that returning to mode 0 is seamless.
  - Arithmetic is evaluated at 32 bits, then compared against the CW-bit t_i.
- Per channel, on tick:
  - If t_i >= P-1: t_i <= 0, and k_i <= (k_i==STEPS-1) ? 0 : k_i+1.
  - Otherwise t_i <= t_i+1.
  - The comparison is >= (not ==). A mode change that shrinks P below the current t_i therefore wraps on the next tick and never runs past the period.
- LED level, computed from the next-state values:
  - mode 0/1: lit when t_i(next) >= DARK_TICKS, dark otherwise.
  - mode 2: lit. mode 3: dark.
  - led is registered and updates on the same edge as the counters, so there is zero extra latency relative to t_i.
  - A mode change to 2 or 3 is reflected at the first edge after mode changes, without waiting for a tick.
- Pause: with en=0, t_i, k_i and led hold. Exception: mode 2/3 still force led. Resume continues exactly where the pattern stopped.
- Channel 0 outputs:
  - step0 mirrors k_0 (registered).
  - cycle_done = 1 for exactly the one cycle after the edge on which k_0 wraps STEPS-1 -> 0. It never fires while paused.
- Simultaneous events:
  - rst beats everything.
  - A tick on a wrap edge both clears t_i and advances k_i. The dark phase of the new period starts on that same edge.

Test Plan (CH=2, TICK_DIV=4, STEPS=3, BASE_TICKS=4, INC_TICKS=2, DARK_TICKS=2, LED_ACTIVE_LOW=1; cycle n = nth clock edge after en rises):
- Reset, then en=1, mode=0 -> led[0]=1 until edge 8, 0 from edge 8 to 16; periods of 16, 24 and 32 clocks for steps 0, 1, 2; step0 goes 0,1,2,0; cycle_done high for one cycle after edge 72, repeating every 72.
- Same run, channel 1 -> starts at step 1: first period 24 clocks (dark 8, lit 16), then 32, then 16.
- en low for 10 cycles at edge 12 -> led, t, k and prescaler frozen; all later transitions occur 10 cycles late; no cycle_done is lost or duplicated.
- mode=1 from reset -> every period 16 clocks (8 dark, 8 lit); step still advances; cycle_done every 48 clocks.
- mode 0 with channel 0 at step 2 and t=6, switch to mode 1 -> wrap at the next tick (t=0, k=0, led=1); cycle_done pulses once.
- mode 2 then mode 3 mid-period -> led=2'b00 then 2'b11 one edge after each change, regardless of tick. Return to mode 0 -> led matches the still-running counters. Then a 1-cycle rst pulse -> led=2'b11, step0=0, k_1=1, prescaler=0 at the next edge.
